c3po_gearbox: RTL and testbench

Parametrised packet down-converter for the c3po datapath. It accepts wide input beats (sop/eop/val, valid-byte count, 4-bit id) and re-emits each forwarded beat as one or more narrow output beats with output back-pressure. Packets whose id does not match the configured port id are dropped. Forwarded and dropped packets are counted. Sits between the c3po ingress bus and the narrow egress bus.

---
 rtl/c3po_gearbox.sv | 204 ++++++++++++++++++++
 tb/tb_c3po_gearbox.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c3po_gearbox.sv
// c3po_gearbox: wide-to-narrow packet gearbox with port-id filtering and packet counters.
// Optional feature macro C3PO_GB_SAT_CNT_EN: counters saturate when defined, wrap when undefined.
//
// state    | meaning
// ST_IDLE  | no beat held; any input beat is accepted immediately
// ST_SLICE | forwarded beat held; slice slice_k of hold_n is presented on the output
module c3po_gearbox #(
  parameter int IN_BYTES   = 160,
  parameter int OUT_BYTES  = 32,
  parameter int VBC_W      = 8,
  parameter int CNT_SIZE_P = 8
) (
  input  logic                    sig_clock,
  input  logic                    sig_reset_L,
  input  logic                    sig_sop,
  input  logic                    sig_eop,
  input  logic                    sig_val,
  input  logic [VBC_W-1:0]        sig_vbc,
  input  logic [3:0]              sig_id,
  input  logic [IN_BYTES*8-1:0]   sig_data,
  input  logic [3:0]              sig_cfg_port_id,
  input  logic                    sig_o_ready,
  output logic                    sig_ready,
  output logic                    sig_o_sop,
  output logic                    sig_o_eop,
  output logic                    sig_o_val,
  output logic [VBC_W-1:0]        sig_o_vbc,
  output logic [OUT_BYTES*8-1:0]  sig_o_data,
  output logic [CNT_SIZE_P-1:0]   sig_cnt0_val,
  output logic [CNT_SIZE_P-1:0]   sig_cnt1_val,
  output logic                    sig_idle
);

  localparam int IW = IN_BYTES * 8;
  localparam int OW = OUT_BYTES * 8;
  localparam logic [VBC_W-1:0]      IN_BYTES_V  = VBC_W'(IN_BYTES);
  localparam logic [VBC_W-1:0]      OUT_BYTES_V = VBC_W'(OUT_BYTES);
  localparam logic [VBC_W-1:0]      ONE_V       = VBC_W'(1);
  localparam logic [CNT_SIZE_P-1:0] CNT_ONE     = CNT_SIZE_P'(1);

  typedef enum logic {ST_IDLE, ST_SLICE} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]    hold_data;
  logic [VBC_W-1:0] hold_vbc;
  logic [VBC_W-1:0] hold_n;
  logic [VBC_W-1:0] slice_k;
  logic             hold_sop;
  logic             hold_eop;
  logic             pkt_open;
  logic             pkt_fwd;

  logic             accept;
  logic             handoff;
  logic             is_last;
  logic             beat_pass;
  logic             open_nxt;
  logic             fwd_nxt;
  logic             load;
  logic             advance;
  logic             cnt0_inc;
  logic             cnt1_inc;
  logic [VBC_W-1:0] vbc_clamp;
  logic [VBC_W-1:0] n_in;

  logic [IW-1:0]    src_data;
  logic [VBC_W-1:0] src_vbc;
  logic [VBC_W-1:0] src_n;
  logic [VBC_W-1:0] src_k;
  logic             src_sop;
  logic             src_eop;
  logic             src_last;
  logic [VBC_W-1:0] src_vbc_o;
  logic [OW-1:0]    src_raw;
  logic [OW-1:0]    src_slice;

  assign vbc_clamp = (sig_vbc > IN_BYTES_V) ? IN_BYTES_V : sig_vbc;
  assign n_in      = (vbc_clamp == '0) ? ONE_V
                   : VBC_W'((int'(vbc_clamp) + OUT_BYTES - 1) / OUT_BYTES);

  assign is_last   = (slice_k == hold_n - ONE_V);
  assign handoff   = sig_o_val & sig_o_ready;
  assign sig_ready = sig_reset_L & ((state == ST_IDLE) | (is_last & sig_o_ready));
  assign accept    = sig_val & sig_ready;
  assign sig_idle  = (state == ST_IDLE) & !pkt_open;
  assign cnt0_inc  = handoff & sig_o_eop;

  // Packet tracking: the forward decision is latched on sop and reused for the body.
  always_comb begin
    beat_pass = 1'b0;
    cnt1_inc  = 1'b0;
    open_nxt  = pkt_open;
    fwd_nxt   = pkt_fwd;
    if (accept) begin
      if (sig_sop) begin
        fwd_nxt   = (sig_id == sig_cfg_port_id);
        open_nxt  = !sig_eop;
        beat_pass = fwd_nxt;
        cnt1_inc  = !fwd_nxt & sig_eop;
      end else if (pkt_open) begin
        beat_pass = pkt_fwd;
        open_nxt  = !sig_eop;
        cnt1_inc  = !pkt_fwd & sig_eop;
      end
    end
  end

  always_ff @(posedge sig_clock or negedge sig_reset_L) begin
    if (!sig_reset_L) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (beat_pass) begin
          load      = 1'b1;
          state_nxt = ST_SLICE;
        end
      end
      ST_SLICE: begin
        if (handoff) begin
          if (!is_last)       advance   = 1'b1;
          else if (beat_pass) load      = 1'b1;
          else                state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One slicer serves both a freshly accepted beat (slice 0) and the held beat (slice k+1).
  always_comb begin
    src_data  = load ? sig_data  : hold_data;
    src_vbc   = load ? vbc_clamp : hold_vbc;
    src_n     = load ? n_in      : hold_n;
    src_sop   = load ? sig_sop   : hold_sop;
    src_eop   = load ? sig_eop   : hold_eop;
    src_k     = load ? '0        : slice_k + ONE_V;
    src_last  = (src_k == src_n - ONE_V);
    src_vbc_o = OUT_BYTES_V;
    if (src_last) src_vbc_o = VBC_W'(int'(src_vbc) - (int'(src_n) - 1) * OUT_BYTES);
    src_raw   = OW'(src_data >> (int'(src_k) * OW));
    src_slice = '0;
    for (int b = 0; b < OUT_BYTES; b++) begin
      if (b < int'(src_vbc_o)) src_slice[b*8 +: 8] = src_raw[b*8 +: 8];
    end
  end

  always_ff @(posedge sig_clock or negedge sig_reset_L) begin
    if (!sig_reset_L) begin
      hold_data    <= '0;
      hold_vbc     <= '0;
      hold_n       <= '0;
      hold_sop     <= 1'b0;
      hold_eop     <= 1'b0;
      slice_k      <= '0;
      pkt_open     <= 1'b0;
      pkt_fwd      <= 1'b0;
      sig_o_val    <= 1'b0;
      sig_o_sop    <= 1'b0;
      sig_o_eop    <= 1'b0;
      sig_o_vbc    <= '0;
      sig_o_data   <= '0;
      sig_cnt0_val <= '0;
      sig_cnt1_val <= '0;
    end else begin
      pkt_open <= open_nxt;
      pkt_fwd  <= fwd_nxt;
      if (load) begin
        hold_data <= src_data;
        hold_vbc  <= src_vbc;
        hold_n    <= src_n;
        hold_sop  <= src_sop;
        hold_eop  <= src_eop;
      end
      if (load | advance) begin
        slice_k    <= src_k;
        sig_o_val  <= 1'b1;
        sig_o_data <= src_slice;
        sig_o_vbc  <= src_vbc_o;
        sig_o_sop  <= src_sop & (src_k == '0);
        sig_o_eop  <= src_eop & src_last;
      end else if (handoff) begin
        sig_o_val  <= 1'b0;
        sig_o_data <= '0;
        sig_o_vbc  <= '0;
        sig_o_sop  <= 1'b0;
        sig_o_eop  <= 1'b0;
      end
`ifdef C3PO_GB_SAT_CNT_EN
      if (cnt0_inc && (sig_cnt0_val != '1)) sig_cnt0_val <= sig_cnt0_val + CNT_ONE;
      if (cnt1_inc && (sig_cnt1_val != '1)) sig_cnt1_val <= sig_cnt1_val + CNT_ONE;
`else
      if (cnt0_inc) sig_cnt0_val <= sig_cnt0_val + CNT_ONE;
      if (cnt1_inc) sig_cnt1_val <= sig_cnt1_val + CNT_ONE;
`endif
    end
  end

endmodule

// File: tb/tb_c3po_gearbox.sv
// Bench for c3po_gearbox: directed steps with randomized payloads, checked against a
// byte-level packet model; counter expectations follow C3PO_GB_SAT_CNT_EN.
module tb_c3po_gearbox;
  localparam int IN_BYTES   = 160;
  localparam int OUT_BYTES  = 32;
  localparam int VBC_W      = 8;
  localparam int CNT_SIZE_P = 8;
  localparam int IW         = IN_BYTES * 8;
  localparam int OW         = OUT_BYTES * 8;
  localparam int CNT_MAX    = (1 << CNT_SIZE_P) - 1;

  typedef struct {
    logic             sop;
    logic             eop;
    logic [VBC_W-1:0] vbc;
    logic [OW-1:0]    data;
  } obeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sop = 1'b0, eop = 1'b0, val = 1'b0;
  logic [VBC_W-1:0] vbc = '0;
  logic [3:0] id = '0;
  logic [IW-1:0] data = '0;
  logic [3:0] cfg = 4'd5;
  logic [3:0] next_cfg = 4'd5;
  logic o_ready = 1'b0;
  logic ready, o_sop, o_eop, o_val, idle;
  logic [VBC_W-1:0] o_vbc;
  logic [OW-1:0] o_data;
  logic [CNT_SIZE_P-1:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;
  int ordy_mode = 0;
  obeat_t exp_q[$];
  obeat_t obs_q[$];
  bit m_open = 0, m_fwd = 0;
  int m_cnt0 = 0, m_cnt1 = 0;

  c3po_gearbox #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .VBC_W(VBC_W),
                 .CNT_SIZE_P(CNT_SIZE_P)) dut (
    .sig_clock(clk), .sig_reset_L(rst_n), .sig_sop(sop), .sig_eop(eop), .sig_val(val),
    .sig_vbc(vbc), .sig_id(id), .sig_data(data), .sig_cfg_port_id(cfg),
    .sig_o_ready(o_ready), .sig_ready(ready), .sig_o_sop(o_sop), .sig_o_eop(o_eop),
    .sig_o_val(o_val), .sig_o_vbc(o_vbc), .sig_o_data(o_data),
    .sig_cnt0_val(cnt0), .sig_cnt1_val(cnt1), .sig_idle(idle));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic int bump(input int c);
`ifdef C3PO_GB_SAT_CNT_EN
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
`else
    return (c + 1) & CNT_MAX;
`endif
  endfunction

  function automatic logic [IW-1:0] rand_data();
    logic [IW-1:0] d;
    for (int i = 0; i < IW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Packet model: forwarding decided on sop, payload cut into OUT_BYTES chunks.
  task automatic model_beat(input bit s, input bit e, input int v_raw, input logic [3:0] bid,
                            input logic [IW-1:0] d);
    int v, n, nb;
    bit pass;
    obeat_t b;
    v = (v_raw > IN_BYTES) ? IN_BYTES : v_raw;
    pass = 0;
    if (s) begin
      m_fwd = (bid == cfg);
      m_open = !e;
      pass = m_fwd;
      if (!m_fwd && e) m_cnt1 = bump(m_cnt1);
    end else if (m_open) begin
      pass = m_fwd;
      if (e) begin
        m_open = 0;
        if (!m_fwd) m_cnt1 = bump(m_cnt1);
      end
    end
    if (pass) begin
      n = (v == 0) ? 1 : (v + OUT_BYTES - 1) / OUT_BYTES;
      for (int j = 0; j < n; j++) begin
        nb = v - j * OUT_BYTES;
        if (nb > OUT_BYTES) nb = OUT_BYTES;
        b.sop = s && (j == 0);
        b.eop = e && (j == n - 1);
        b.vbc = VBC_W'(nb);
        b.data = '0;
        for (int i = 0; i < nb; i++) b.data[i*8 +: 8] = d[(j*OUT_BYTES + i)*8 +: 8];
        exp_q.push_back(b);
      end
      if (e) m_cnt0 = bump(m_cnt0);
    end
  endtask

  // Called at a rising edge; returns at the rising edge that accepted the beat.
  task automatic send_beat(input bit s, input bit e, input int v, input logic [3:0] bid,
                           input logic [IW-1:0] d, output int waited);
    bit ok;
    #1;
    cfg = next_cfg;
    sop = s; eop = e; vbc = VBC_W'(v); id = bid; data = d; val = 1'b1;
    waited = 0;
    ok = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (ready) begin ok = 1; break; end
      waited++;
    end
    check("accept_timeout", OW'(ok), OW'(1));
    @(posedge clk);
    if (ok) model_beat(s, e, v, bid, d);
  endtask

  task automatic drain(input string name);
    bit ok;
    int nmin;
    #1;
    val = 1'b0; sop = 1'b0; eop = 1'b0;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (obs_q.size() >= exp_q.size() && !o_val) begin ok = 1; break; end
    end
    check({name, ".drain_timeout"}, OW'(ok), OW'(1));
    check({name, ".nbeats"}, OW'(obs_q.size()), OW'(exp_q.size()));
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check($sformatf("%s.sop[%0d]", name, i), OW'(obs_q[i].sop), OW'(exp_q[i].sop));
      check($sformatf("%s.eop[%0d]", name, i), OW'(obs_q[i].eop), OW'(exp_q[i].eop));
      check($sformatf("%s.vbc[%0d]", name, i), OW'(obs_q[i].vbc), OW'(exp_q[i].vbc));
      check($sformatf("%s.data[%0d]", name, i), obs_q[i].data, exp_q[i].data);
    end
    check({name, ".cnt0"}, OW'(cnt0), OW'(m_cnt0));
    check({name, ".cnt1"}, OW'(cnt1), OW'(m_cnt1));
    check({name, ".idle"}, OW'(idle), OW'(!m_open));
    check({name, ".ready"}, OW'(ready), OW'(1));
    exp_q.delete();
    obs_q.delete();
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    val = 1'b0; sop = 1'b0; eop = 1'b0;
    @(negedge clk);
    check("rst.o_val", OW'(o_val), OW'(0));
    check("rst.o_sop", OW'(o_sop), OW'(0));
    check("rst.o_eop", OW'(o_eop), OW'(0));
    check("rst.o_vbc", OW'(o_vbc), OW'(0));
    check("rst.o_data", o_data, OW'(0));
    check("rst.cnt0", OW'(cnt0), OW'(0));
    check("rst.cnt1", OW'(cnt1), OW'(0));
    check("rst.ready", OW'(ready), OW'(0));
    check("rst.idle", OW'(idle), OW'(1));
    m_open = 0; m_cnt0 = 0; m_cnt1 = 0;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (ordy_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = !o_ready;
      default: o_ready = 1'($urandom % 2);
    endcase
  end

  // Output monitor: records handoffs, checks hold-while-stalled and input accept timing.
  initial begin
    obeat_t b, p;
    bit stalled;
    stalled = 0;
    p.sop = 0; p.eop = 0; p.vbc = '0; p.data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 0;
      else begin
        if (stalled) begin
          check("hold.o_val", OW'(o_val), OW'(1));
          check("hold.o_sop", OW'(o_sop), OW'(p.sop));
          check("hold.o_eop", OW'(o_eop), OW'(p.eop));
          check("hold.o_vbc", OW'(o_vbc), OW'(p.vbc));
          check("hold.o_data", o_data, p.data);
        end
        if (val && ready && o_val) begin
          check("acc.o_ready", OW'(o_ready), OW'(1));
          check("acc.last_slice", OW'(exp_q.size() - obs_q.size()), OW'(1));
        end
        if (o_val && o_ready) begin
          b.sop = o_sop; b.eop = o_eop; b.vbc = o_vbc; b.data = o_data;
          obs_q.push_back(b);
        end
        stalled = o_val && !o_ready;
        p.sop = o_sop; p.eop = o_eop; p.vbc = o_vbc; p.data = o_data;
      end
    end
  end

  initial begin
    int w, low, nb, cnt_exp;
    bit s, e, ok;
    logic [3:0] bid;

    do_reset();

    // single 160-byte beat, full throughput
    ordy_mode = 0;
    send_beat(1, 1, 160, 4'd5, rand_data(), w);
    #1 val = 1'b0;
    low = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ready) break;
      low++;
    end
    check("t1.ready_low_cycles", OW'(low), OW'(4));
    drain("t1");

    // two-beat packet 160 + 70
    send_beat(1, 0, 160, 4'd5, rand_data(), w);
    send_beat(0, 1, 70, 4'd0, rand_data(), w);
    drain("t2");

    // dropped 3-beat packet, then a matching single beat
    send_beat(1, 0, 100, 4'd3, rand_data(), w);
    check("t3.drop_ready0", OW'(w), OW'(0));
    send_beat(0, 0, 160, 4'd5, rand_data(), w);
    check("t3.drop_ready1", OW'(w), OW'(0));
    send_beat(0, 1, 40, 4'd5, rand_data(), w);
    check("t3.drop_ready2", OW'(w), OW'(0));
    send_beat(1, 1, 90, 4'd5, rand_data(), w);
    drain("t3");

    // toggled back-pressure with multi-beat packets, including clamp and empty beats
    ordy_mode = 1;
    send_beat(1, 0, 200, 4'd5, rand_data(), w);
    send_beat(0, 0, 0, 4'd5, rand_data(), w);
    send_beat(0, 1, $urandom_range(1, 160), 4'd5, rand_data(), w);
    for (int pk = 0; pk < 4; pk++) begin
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++)
        send_beat(j == 0, j == nb - 1, $urandom_range(0, 200), 4'd5, rand_data(), w);
    end
    drain("t4");

    // random flags, ids, strays, cfg changes and random back-pressure
    ordy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      s = ($urandom % 3) == 0;
      e = ($urandom % 3) == 0;
      if (($urandom % 8) == 0) next_cfg = 4'($urandom % 16);
      bid = ($urandom % 2) ? next_cfg : 4'($urandom % 16);
      send_beat(s, e, $urandom_range(0, 200), bid, rand_data(), w);
    end
    drain("t5");

    // 256 single-byte packets from a cleared counter
    next_cfg = 4'd5;
    ordy_mode = 0;
    do_reset();
    for (int i = 0; i < 256; i++) send_beat(1, 1, 1, 4'd5, rand_data(), w);
    drain("t6");
`ifdef C3PO_GB_SAT_CNT_EN
    cnt_exp = CNT_MAX;
`else
    cnt_exp = 0;
`endif
    check("t6.cnt0_after_256", OW'(cnt0), OW'(cnt_exp));

    // reset while slice 2 of a 160-byte beat is presented
    send_beat(1, 1, 160, 4'd5, rand_data(), w);
    #1 val = 1'b0;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() == 3) begin ok = 1; break; end
    end
    check("t7.reach_slice2", OW'(ok), OW'(1));
    rst_n = 1'b0;
    #1;
    check("t7.async_o_val", OW'(o_val), OW'(0));
    check("t7.async_ready", OW'(ready), OW'(0));
    do_reset();
    send_beat(1, 1, 120, 4'd5, rand_data(), w);
    drain("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
